// File: rtl/filter_spad_ctrl.sv
// Filter scratchpad sequencer: loads a filter from an upstream stream, then replays
// its rows once per output window to the MAC over a backpressured valid/ready port.
module filter_spad_ctrl #(
  parameter int unsigned FILTER_ROW = 12,
  parameter int unsigned ADDR_W     = $clog2(FILTER_ROW),
  parameter int unsigned WIN_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_keep_filter,
  input  logic [ADDR_W:0]   i_filter_size,
  input  logic [WIN_W-1:0]  i_window_count,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  output logic              o_spad_wen,
  output logic [ADDR_W-1:0] o_spad_waddr,
  output logic              o_spad_ren,
  output logic [ADDR_W-1:0] o_spad_raddr,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic              o_out_last_row,
  output logic              o_out_last_win,
  output logic              o_busy,
  output logic              o_done
);

  localparam int unsigned SIZE_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COMPUTE,
    ST_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [SIZE_W-1:0]   r_size;
  logic [WIN_W-1:0]    r_win_total;
  logic [ADDR_W-1:0]   r_load_cnt;
  logic [ADDR_W-1:0]   r_row_cnt;
  logic [WIN_W-1:0]    r_win_cnt;
  logic                r_all_issued;
  logic                r_resident;
  logic [SIZE_W-1:0]   r_res_size;
  logic                r_out_valid;
  logic                r_out_last_row;
  logic                r_out_last_win;
  logic                r_in_ready;
  logic                r_busy;
  logic                r_done;

  logic [SIZE_W-1:0]   w_eff;
  logic [SIZE_W-1:0]   w_size_m1;
  logic                w_load_last;
  logic                w_row_last;
  logic                w_win_last;
  logic                w_wen;
  logic                w_issue;

  // Requests larger than the scratchpad are clamped to its depth.
  assign w_eff       = (i_filter_size > SIZE_W'(FILTER_ROW)) ? SIZE_W'(FILTER_ROW) : i_filter_size;
  assign w_size_m1   = r_size - SIZE_W'(1);
  assign w_load_last = (SIZE_W'(r_load_cnt) == w_size_m1);
  assign w_row_last  = (SIZE_W'(r_row_cnt) == w_size_m1);
  assign w_win_last  = (r_win_cnt == (r_win_total - WIN_W'(1)));

  // Next-state and per-cycle strobes.
  always_comb begin
    w_next  = r_state;
    w_wen   = 1'b0;
    w_issue = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          if (w_eff == '0)
            w_next = ST_DONE;
          else if (i_keep_filter && r_resident && (w_eff == r_res_size))
            w_next = ST_COMPUTE;
          else
            w_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_wen = i_in_valid;
        if (i_in_valid && w_load_last)
          w_next = (r_win_total == '0) ? ST_DONE : ST_COMPUTE;
      end
      ST_COMPUTE: begin
        w_issue = (!r_out_valid || i_out_ready) && !r_all_issued;
        if (r_all_issued && (!r_out_valid || i_out_ready))
          w_next = ST_DONE;
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  // Job registers, counters and the registered MAC-side handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_size         <= '0;
      r_win_total    <= '0;
      r_load_cnt     <= '0;
      r_row_cnt      <= '0;
      r_win_cnt      <= '0;
      r_all_issued   <= 1'b0;
      r_resident     <= 1'b0;
      r_res_size     <= '0;
      r_out_valid    <= 1'b0;
      r_out_last_row <= 1'b0;
      r_out_last_win <= 1'b0;
      r_in_ready     <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_in_ready <= (w_next == ST_LOAD);
      r_busy     <= (w_next != ST_IDLE);
      r_done     <= (w_next == ST_DONE);

      if ((r_state == ST_IDLE) && i_start) begin
        r_size       <= w_eff;
        r_win_total  <= i_window_count;
        r_load_cnt   <= '0;
        r_row_cnt    <= '0;
        r_win_cnt    <= '0;
        r_all_issued <= (i_window_count == '0);
        // A reload overwrites the scratchpad, so the old filter stops being resident.
        if (w_next == ST_LOAD)
          r_resident <= 1'b0;
      end

      if (w_wen) begin
        r_load_cnt <= r_load_cnt + ADDR_W'(1);
        if (w_load_last) begin
          r_resident <= 1'b1;
          r_res_size <= r_size;
        end
      end

      if (w_issue) begin
        r_out_valid    <= 1'b1;
        r_out_last_row <= w_row_last;
        r_out_last_win <= w_win_last;
        if (w_row_last) begin
          r_row_cnt <= '0;
          r_win_cnt <= r_win_cnt + WIN_W'(1);
          if (w_win_last)
            r_all_issued <= 1'b1;
        end else begin
          r_row_cnt <= r_row_cnt + ADDR_W'(1);
        end
      end else if (i_out_ready) begin
        r_out_valid    <= 1'b0;
        r_out_last_row <= 1'b0;
        r_out_last_win <= 1'b0;
      end
    end
  end

  assign o_in_ready     = r_in_ready;
  assign o_spad_wen     = w_wen;
  assign o_spad_waddr   = w_wen ? r_load_cnt : '0;
  assign o_spad_ren     = w_issue;
  assign o_spad_raddr   = w_issue ? r_row_cnt : '0;
  assign o_out_valid    = r_out_valid;
  assign o_out_last_row = r_out_last_row;
  assign o_out_last_win = r_out_last_win;
  assign o_busy         = r_busy;
  assign o_done         = r_done;

endmodule
